// File: rtl/mult_div.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers.
// One radix-2 step per cycle; results land in hi/lo 33 edges after start.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic        s1_q, s2_q, dz_q;
    logic [4:0]  cnt_q;
    logic [31:0] a_q;
    logic [63:0] p_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;

    logic        sgn_in, sgn_q;
    logic [31:0] abs1, abs2;
    logic [32:0] mul_t;
    logic [32:0] rem_sh;
    logic [31:0] rem_df;
    logic        ge;
    logic [63:0] p_d;
    logic [63:0] prod_d;
    logic [31:0] quo_d, rmd_d;
    logic [31:0] hi_d, lo_d;

    assign sgn_in = ~op[0];
    assign abs1   = (sgn_in && in1[31]) ? -in1 : in1;
    assign abs2   = (sgn_in && in2[31]) ? -in2 : in2;

    // p_q holds {partial, multiplier} or {remainder, dividend/quotient}
    assign mul_t  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
    assign rem_sh = {p_q[63:32], p_q[31]};
    assign rem_df = rem_sh[31:0] - a_q;
    assign ge     = rem_sh >= {1'b0, a_q};

    always_comb begin
        p_d = {mul_t, p_q[31:1]};
        if (op_q[1])
            p_d = {(ge ? rem_df : rem_sh[31:0]), p_q[30:0], ge};
    end

    assign sgn_q  = ~op_q[0];
    assign prod_d = (sgn_q && (s1_q ^ s2_q)) ? -p_q : p_q;
    assign rmd_d  = (sgn_q && s1_q) ? -p_q[63:32] : p_q[63:32];

    // Divide by zero forces an all-ones quotient regardless of signs
    always_comb begin
        quo_d = p_q[31:0];
        if (dz_q)
            quo_d = 32'hFFFF_FFFF;
        else if (sgn_q && (s1_q ^ s2_q))
            quo_d = -p_q[31:0];
    end

    assign hi_d = op_q[1] ? rmd_d : prod_d[63:32];
    assign lo_d = op_q[1] ? quo_d : prod_d[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            p_q     <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        s1_q    <= in1[31];
                        s2_q    <= in2[31];
                        dz_q    <= (in2 == 32'd0);
                        a_q     <= abs2;
                        p_q     <= {32'd0, abs1};
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        if (mthi) hi_q <= in1;
                        if (mtlo) lo_q <= in1;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_q <= FINISH;
                end
                FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: latency, signed/unsigned results,
// divide-by-zero, busy-time ignore rules, moves and mid-op reset.
module tb_mult_div;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1, in2;
    logic        mthi, mtlo;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mh = 32'd0;
    logic [31:0] ml = 32'd0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01;
    localparam logic [1:0] DIV = 2'b10, DIVU = 2'b11;

    mult_div dut (
        .clk(clk), .reset(rst), .start(start), .op(op),
        .in1(in1), .in2(in2), .mthi(mthi), .mtlo(mtlo),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at E0, check busy through E32, results and done at E33
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; in1 = a; in2 = b;
        tick();
        start = 1'b0;
        chk({tag, "_acc"}, {62'd0, busy, done}, 64'd2);
        repeat (31) tick();
        chk({tag, "_run"}, {busy, done, hi, lo}, {2'b10, mh, ml});
        tick();
        chk({tag, "_e32"}, {62'd0, busy, done}, 64'd2);
        tick();
        chk({tag, "_res"}, {busy, done, hi, lo}, {2'b01, eh, el});
        mh = eh; ml = el;
        tick();
        chk({tag, "_dn0"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00;
        in1 = 32'd0; in2 = 32'd0; mthi = 1'b0; mtlo = 1'b0;
        #12;
        chk("rst_state", {busy, done, hi, lo}, 66'd0);
        rst = 1'b0;
        tick();

        run_op("mult_7x-3", MULT, 32'd7, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_min", MULT, 32'hFFFF_FFFF, 32'h8000_0000,
               32'h0000_0000, 32'h8000_0000);
        run_op("div_-7/2", DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
        run_op("div_7/-2", DIV, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD);
        run_op("divu_dz", DIVU, 32'd100, 32'd0,
               32'd100, 32'hFFFF_FFFF);
        run_op("div_dz_neg", DIV, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Busy-time start and mthi must be ignored
        start = 1'b1; op = DIVU; in1 = 32'd100; in2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = MULT; in1 = 32'hDEAD_BEEF; in2 = 32'd3;
        mthi = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0; in1 = 32'd9; in2 = 32'd9;
        chk("busy_mthi", {32'd0, hi}, {32'd0, mh});
        repeat (27) tick();
        chk("busy_e32", {62'd0, busy, done}, 64'd2);
        tick();
        chk("divu_100/7", {busy, done, hi, lo}, {2'b01, 32'd2, 32'd14});
        mh = 32'd2; ml = 32'd14;
        tick();
        chk("no_restart", {62'd0, busy, done}, 64'd0);

        mtlo = 1'b1; in1 = 32'h1234_5678;
        tick();
        mtlo = 1'b0;
        chk("mtlo", {hi, lo}, {32'd2, 32'h1234_5678});
        ml = 32'h1234_5678;

        mthi = 1'b1; mtlo = 1'b1; in1 = 32'hCAFE_0001;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'hCAFE_0001, 32'hCAFE_0001});
        mh = 32'hCAFE_0001; ml = 32'hCAFE_0001;

        // start wins over a simultaneous move
        mthi = 1'b1;
        run_op("start_prio", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
        mthi = 1'b0;

        // Mid-operation reset
        start = 1'b1; op = MULTU; in1 = 32'd3; in2 = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid", {busy, done, hi, lo}, 66'd0);
        tick();
        chk("rst_hold", {busy, done, hi, lo}, 66'd0);
        rst = 1'b0;
        mh = 32'd0; ml = 32'd0;
        tick();
        chk("rst_nodone", {62'd0, busy, done}, 64'd0);
        run_op("after_rst", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
